// File: rtl/syncfifo_pkg.sv
// Shared defaults and helpers for the parametrised sync FIFO.
// Parity helper is used only when SYNCFIFO_PARITY_EN is defined.
package syncfifo_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 64;
  // Parity is width-agnostic: callers zero-extend, which leaves XOR parity unchanged.
  localparam int PAR_MAX_W = 1024;

  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/syncfifo_mem.sv
// DEPTH x W storage: one write port, one registered read port, no array reset.
// Only the read-data register is reset so dout starts at zero.
module syncfifo_mem #(
  parameter int W     = 32,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_array [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_array[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)   rdata <= '0;
    else if (re) rdata <= mem_array[raddr];
  end

endmodule

// File: rtl/syncfifo_param.sv
// Parametrised single-clock circular FIFO with count, thresholds, sticky errors, flush.
// Define SYNCFIFO_PARITY_EN to store and check an even-parity bit per word.
module syncfifo_param
  import syncfifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AFULL_TH  = 56,
  parameter int AEMPTY_TH = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     we,
  input  logic [WIDTH-1:0]         din,
  input  logic                     re,
  input  logic                     flush,
  input  logic                     clr_err,
  output logic [WIDTH-1:0]         dout,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     afull,
  output logic                     aempty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     parity_err
);

  localparam int AW = $clog2(DEPTH);
`ifdef SYNCFIFO_PARITY_EN
  localparam int MW = WIDTH + 1;
`else
  localparam int MW = WIDTH;
`endif

  logic [AW:0]   wr_ptr_reg, rd_ptr_reg, count_reg, count_next;
  logic          rd_valid_reg, overflow_reg, underflow_reg;
  logic          wr_acc, rd_acc, wr_go, rd_go;
  logic [MW-1:0] mem_wdata, mem_rdata;

  assign full   = (count_reg == (AW+1)'(DEPTH));
  assign empty  = (count_reg == '0);
  assign afull  = (count_reg >= (AW+1)'(AFULL_TH));
  assign aempty = (count_reg <= (AW+1)'(AEMPTY_TH));

  assign wr_acc = we & ~full;
  assign rd_acc = re & ~empty;
  // Flush swallows both requests; it also suppresses the error flags they would raise.
  assign wr_go  = wr_acc & ~flush;
  assign rd_go  = rd_acc & ~flush;

  assign count_next = count_reg + {{AW{1'b0}}, wr_go} - {{AW{1'b0}}, rd_go};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      rd_valid_reg  <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr_reg   <= '0;
        rd_ptr_reg   <= '0;
        count_reg    <= '0;
        rd_valid_reg <= 1'b0;
      end else begin
        if (wr_go) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
        if (rd_go) rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
        count_reg    <= count_next;
        rd_valid_reg <= rd_go;
      end
      if (we & full & ~flush) overflow_reg <= 1'b1;
      else if (clr_err)       overflow_reg <= 1'b0;
      if (re & empty & ~flush) underflow_reg <= 1'b1;
      else if (clr_err)        underflow_reg <= 1'b0;
    end
  end

`ifdef SYNCFIFO_PARITY_EN
  assign mem_wdata  = {even_parity(PAR_MAX_W'(din)), din};
  // Checked on the registered read word, so the pulse lines up with rd_valid.
  assign parity_err = rd_valid_reg &
                      (even_parity(PAR_MAX_W'(mem_rdata[WIDTH-1:0])) != mem_rdata[WIDTH]);
`else
  assign mem_wdata  = din;
  assign parity_err = 1'b0;
`endif

  syncfifo_mem #(
    .W     (MW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .rstn  (rstn),
    .we    (wr_go),
    .waddr (wr_ptr_reg[AW-1:0]),
    .wdata (mem_wdata),
    .re    (rd_go),
    .raddr (rd_ptr_reg[AW-1:0]),
    .rdata (mem_rdata)
  );

  assign dout      = mem_rdata[WIDTH-1:0];
  assign rd_valid  = rd_valid_reg;
  assign count     = count_reg;
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

endmodule
